// File: rtl/psg_mixer.sv
// PSG mixer: snapshots the four channel levels on a sample tick, then
// accumulates the enabled channels over four cycles, applies the master
// volume and PSG ratio, and presents one left/right sample pair with a strobe.
module psg_mixer (
  input  logic        system_clock,
  input  logic        reset,
  input  logic [23:0] ch1_wave,
  input  logic [23:0] ch2_wave,
  input  logic [23:0] ch3_wave,
  input  logic [23:0] ch4_wave,
  input  logic [15:0] soundcnt_l,
  input  logic [1:0]  soundcnt_h,
  input  logic        master_enable,
  input  logic        sample_tick,
  output logic [25:0] psg_left,
  output logic [25:0] psg_right,
  output logic        out_valid,
  output logic        overrun
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACC   = 2'd1,
    SCALE = 2'd2,
    OUT   = 2'd3
  } state_t;

  state_t      r_state;
  logic [1:0]  r_idx;
  logic [23:0] r_ch1;
  logic [23:0] r_ch2;
  logic [23:0] r_ch3;
  logic [23:0] r_ch4;
  logic [15:0] r_cnt_l;
  logic [1:0]  r_ratio;
  logic [25:0] r_acc_l;
  logic [25:0] r_acc_r;
  logic [25:0] r_res_l;
  logic [25:0] r_res_r;

  logic [23:0] w_ch_sel;
  logic [3:0]  w_en_l;
  logic [3:0]  w_en_r;
  logic [3:0]  w_mul_l;
  logic [3:0]  w_mul_r;
  logic [1:0]  w_shift;
  logic [28:0] w_prod_l;
  logic [28:0] w_prod_r;
  logic [28:0] w_shr_l;
  logic [28:0] w_shr_r;

  // Pick the snapshot channel addressed by the ACC index and derive the scale terms.
  always_comb begin
    w_ch_sel = r_ch1;
    case (r_idx)
      2'd0: w_ch_sel = r_ch1;
      2'd1: w_ch_sel = r_ch2;
      2'd2: w_ch_sel = r_ch3;
      2'd3: w_ch_sel = r_ch4;
      default: w_ch_sel = r_ch1;
    endcase

    w_en_l  = r_cnt_l[15:12];
    w_en_r  = r_cnt_l[11:8];
    w_mul_l = {1'b0, r_cnt_l[6:4]} + 4'd1;
    w_mul_r = {1'b0, r_cnt_l[2:0]} + 4'd1;

    case (r_ratio)
      2'd0:    w_shift = 2'd2;
      2'd1:    w_shift = 2'd1;
      default: w_shift = 2'd0;
    endcase

    // Product of a 26-bit sum and a multiplier of at most 8 always fits 29 bits.
    w_prod_l = {3'b000, r_acc_l} * {25'd0, w_mul_l};
    w_prod_r = {3'b000, r_acc_r} * {25'd0, w_mul_r};
    w_shr_l  = (w_prod_l >> 3) >> w_shift;
    w_shr_r  = (w_prod_r >> 3) >> w_shift;
  end

  // Sequencer: capture, four accumulate steps, scale, then publish the sample.
  always_ff @(posedge system_clock) begin
    if (reset) begin
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      r_ch1     <= 24'd0;
      r_ch2     <= 24'd0;
      r_ch3     <= 24'd0;
      r_ch4     <= 24'd0;
      r_cnt_l   <= 16'd0;
      r_ratio   <= 2'd0;
      r_acc_l   <= 26'd0;
      r_acc_r   <= 26'd0;
      r_res_l   <= 26'd0;
      r_res_r   <= 26'd0;
      psg_left  <= 26'd0;
      psg_right <= 26'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (!master_enable) begin
      // Disabling abandons any sample in flight and silences the outputs.
      r_state   <= IDLE;
      r_idx     <= 2'd0;
      psg_left  <= 26'd0;
      psg_right <= 26'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      overrun   <= sample_tick && (r_state != IDLE);
      case (r_state)
        IDLE: begin
          if (sample_tick) begin
            r_ch1   <= ch1_wave;
            r_ch2   <= ch2_wave;
            r_ch3   <= ch3_wave;
            r_ch4   <= ch4_wave;
            r_cnt_l <= soundcnt_l;
            r_ratio <= soundcnt_h;
            r_acc_l <= 26'd0;
            r_acc_r <= 26'd0;
            r_idx   <= 2'd0;
            r_state <= ACC;
          end
        end
        ACC: begin
          if (w_en_l[r_idx]) r_acc_l <= r_acc_l + {2'b00, w_ch_sel};
          if (w_en_r[r_idx]) r_acc_r <= r_acc_r + {2'b00, w_ch_sel};
          r_idx <= r_idx + 2'd1;
          if (r_idx == 2'd3) r_state <= SCALE;
        end
        SCALE: begin
          r_res_l <= w_shr_l[25:0];
          r_res_r <= w_shr_r[25:0];
          r_state <= OUT;
        end
        OUT: begin
          psg_left  <= r_res_l;
          psg_right <= r_res_r;
          out_valid <= 1'b1;
          r_state   <= IDLE;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule
